// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, error codes and register bundle for the UART frame parser
package uart_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_LEN, ST_PAYLOAD, ST_CSUM} state_e;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_LEN = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  typedef struct packed {
    state_e     state;
    logic [7:0] cmd;
    logic [7:0] len;
    logic [7:0] csum;
    logic [7:0] idx;
    logic [7:0] data_byte;
    logic [7:0] data_idx;
    logic       data_valid;
    logic       frame_valid;
    logic       frame_err;
    logic [1:0] err_code;
  } regs_t;
  localparam regs_t REGS_RST = '{state: ST_IDLE, cmd: 8'h0, len: 8'h0, csum: 8'h0, idx: 8'h0,
                                 data_byte: 8'h0, data_idx: 8'h0, data_valid: 1'b0,
                                 frame_valid: 1'b0, frame_err: 1'b0, err_code: ERR_NONE};
endpackage

// File: rtl/uart_timeout_cnt.sv
// uart_timeout_cnt: counts cycles since the last clear while enabled, flags expiry at TimeoutClks-1
module uart_timeout_cnt #(
  parameter int TimeoutClks = 3472
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam int W = $clog2(TimeoutClks + 1);
  logic [W-1:0] cnt_q, cnt_d;
  // o_tc fires on the cycle whose increment reaches TimeoutClks-1, so the registered error lands on that edge
  always_comb begin
    cnt_d = (i_clr || !i_en) ? '0 : cnt_q + W'(1);
    o_tc = i_en && !i_clr && cnt_q == W'(TimeoutClks - 2);
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: assembles SYNC/CMD/LEN/payload/CSUM frames from uart_rx byte strobes
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0] SyncByte = SYNC_BYTE,
  parameter int MaxLen = 16,
  parameter int TimeoutClks = 3472
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_byte,
  output logic [7:0] o_cmd,
  output logic [7:0] o_len,
  output logic       o_data_valid,
  output logic [7:0] o_data_byte,
  output logic [7:0] o_data_idx,
  output logic       o_frame_valid,
  output logic       o_frame_err,
  output logic [1:0] o_err_code
);
  regs_t r_q, r_d;
  logic tmo, len_bad, csum_ok;
  assign len_bad = i_rx_byte > 8'(MaxLen);
  assign csum_ok = i_rx_byte == r_q.csum;
  uart_timeout_cnt #(.TimeoutClks(TimeoutClks)) u_tmo (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (i_rx_valid),
    .i_en   (r_q.state != ST_IDLE),
    .o_tc   (tmo)
  );
  // a byte strobe always takes priority over a coincident timeout
  always_comb begin
    r_d = r_q;
    r_d.data_valid = 1'b0;
    r_d.frame_valid = 1'b0;
    r_d.frame_err = 1'b0;
    if (i_rx_valid) begin
      case (r_q.state)
        ST_IDLE: r_d.state = i_rx_byte == SyncByte ? ST_CMD : ST_IDLE;
        ST_CMD: begin
          r_d.cmd = i_rx_byte;
          r_d.csum = i_rx_byte;
          r_d.state = ST_LEN;
        end
        ST_LEN: begin
          r_d.len = i_rx_byte;
          r_d.csum = r_q.csum + i_rx_byte;
          r_d.idx = '0;
          r_d.frame_err = len_bad;
          r_d.err_code = len_bad ? ERR_LEN : r_q.err_code;
          r_d.state = len_bad ? ST_IDLE : i_rx_byte == 8'd0 ? ST_CSUM : ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          r_d.data_valid = 1'b1;
          r_d.data_byte = i_rx_byte;
          r_d.data_idx = r_q.idx;
          r_d.csum = r_q.csum + i_rx_byte;
          r_d.idx = r_q.idx + 8'd1;
          r_d.state = r_q.idx == r_q.len - 8'd1 ? ST_CSUM : ST_PAYLOAD;
        end
        ST_CSUM: begin
          r_d.frame_valid = csum_ok;
          r_d.frame_err = !csum_ok;
          r_d.err_code = csum_ok ? r_q.err_code : ERR_CSUM;
          r_d.state = ST_IDLE;
        end
        default: r_d.state = ST_IDLE;
      endcase
    end else if (tmo) begin
      r_d.frame_err = 1'b1;
      r_d.err_code = ERR_TIMEOUT;
      r_d.state = ST_IDLE;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_q <= REGS_RST;
    else r_q <= r_d;
  end
  assign o_cmd = r_q.cmd;
  assign o_len = r_q.len;
  assign o_data_valid = r_q.data_valid;
  assign o_data_byte = r_q.data_byte;
  assign o_data_idx = r_q.data_idx;
  assign o_frame_valid = r_q.frame_valid;
  assign o_frame_err = r_q.frame_err;
  assign o_err_code = r_q.err_code;
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: directed and randomized frames checked against a frame-level reference model
module tb_uart_frame_parser;
  localparam int MAXLEN = 16;
  localparam int TC = 3472;
  typedef logic [7:0] bq_t[$];
  logic i_clk = 1'b0, i_rst_n = 1'b0, i_rx_valid = 1'b0;
  logic [7:0] i_rx_byte = 8'h0;
  logic [7:0] o_cmd, o_len, o_data_byte, o_data_idx;
  logic o_data_valid, o_frame_valid, o_frame_err;
  logic [1:0] o_err_code;
  int tests = 0, fails = 0;
  logic [7:0] m_cmd = 8'h0, m_len = 8'h0, m_db = 8'h0, m_di = 8'h0;
  logic [1:0] m_ec = 2'd0;
  bq_t none;

  uart_frame_parser dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_rx_valid   (i_rx_valid),
    .i_rx_byte    (i_rx_byte),
    .o_cmd        (o_cmd),
    .o_len        (o_len),
    .o_data_valid (o_data_valid),
    .o_data_byte  (o_data_byte),
    .o_data_idx   (o_data_idx),
    .o_frame_valid(o_frame_valid),
    .o_frame_err  (o_frame_err),
    .o_err_code   (o_err_code)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // full output vector: {dv, byte, idx, fv, fe, code, cmd, len}
  task automatic chk_out(input string tag, input bit dv, input bit fv, input bit fe);
    chk(tag, {27'd0, o_data_valid, o_data_byte, o_data_idx, o_frame_valid, o_frame_err, o_err_code, o_cmd, o_len},
             {27'd0, dv, m_db, m_di, fv, fe, m_ec, m_cmd, m_len});
  endtask

  function automatic int g(input int gap);
    return gap > 0 ? gap : int'($urandom_range(1, 5));
  endfunction

  // strobe one byte, check the registered response, then check gap-1 quiet cycles
  task automatic send(input logic [7:0] b, input int gap, input bit dv, input bit fv, input bit fe,
                      input string tag);
    i_rx_byte = b;
    i_rx_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_rx_valid = 1'b0;
    chk_out(tag, dv, fv, fe);
    repeat (gap - 1) begin
      @(posedge i_clk);
      #1;
      chk_out("idle", 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic frame(input logic [7:0] c, input logic [7:0] l, input bq_t pl, input bit bad, input int gap);
    logic [7:0] s;
    send(8'hA5, g(gap), 1'b0, 1'b0, 1'b0, "sync");
    m_cmd = c;
    send(c, g(gap), 1'b0, 1'b0, 1'b0, "cmd");
    m_len = l;
    s = c + l;
    if (l > 8'(MAXLEN)) begin
      m_ec = 2'd2;
      send(l, g(gap), 1'b0, 1'b0, 1'b1, "len_err");
      return;
    end
    send(l, g(gap), 1'b0, 1'b0, 1'b0, "len");
    foreach (pl[i]) begin
      m_db = pl[i];
      m_di = 8'(i);
      s += pl[i];
      send(pl[i], g(gap), 1'b1, 1'b0, 1'b0, "data");
    end
    if (bad) m_ec = 2'd1;
    send(bad ? s + 8'(1 + $urandom_range(0, 254)) : s, g(gap), 1'b0, !bad, bad, bad ? "csum_bad" : "csum_ok");
  endtask

  task automatic expect_timeout(input string tag);
    int n = 0;
    while (!o_frame_err && n < TC + 8) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    chk({tag, "_cycles"}, 64'(n), 64'(TC - 1));
    m_ec = 2'd3;
    chk_out(tag, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bq_t q;
    int kind, n, ntmo;
    logic [7:0] c, l, b;
    ntmo = 0;
    repeat (2) @(posedge i_clk);
    #1;
    chk_out("reset", 1'b0, 1'b0, 1'b0);
    i_rst_n = 1'b1;
    frame(8'h01, 8'h02, '{8'h10, 8'h20}, 1'b0, 0);
    frame(8'hFF, 8'h01, '{8'h02}, 1'b0, 0);
    frame(8'hFF, 8'h01, '{8'h02}, 1'b1, 0);
    frame(8'h07, 8'h11, none, 1'b0, 0);
    frame(8'h05, 8'h00, none, 1'b0, 0);
    send(8'h00, 2, 1'b0, 1'b0, 1'b0, "junk");
    send(8'hFF, 2, 1'b0, 1'b0, 1'b0, "junk");
    frame(8'hA5, 8'h00, none, 1'b0, 0);
    frame(8'h33, 8'h03, '{8'hA5, 8'hA5, 8'h00}, 1'b0, 1);
    send(8'hA5, 2, 1'b0, 1'b0, 1'b0, "sync");
    m_cmd = 8'h03;
    send(8'h03, 2, 1'b0, 1'b0, 1'b0, "cmd");
    m_len = 8'h02;
    send(8'h02, 2, 1'b0, 1'b0, 1'b0, "len");
    m_db = 8'h10;
    m_di = 8'h00;
    send(8'h10, 1, 1'b1, 1'b0, 1'b0, "data");
    expect_timeout("timeout");
    send(8'hA5, 2, 1'b0, 1'b0, 1'b0, "sync");
    send(8'h03, 2, 1'b0, 1'b0, 1'b0, "cmd");
    send(8'h02, 2, 1'b0, 1'b0, 1'b0, "len");
    send(8'h10, TC - 1, 1'b1, 1'b0, 1'b0, "data");
    m_db = 8'h20;
    m_di = 8'h01;
    send(8'h20, 2, 1'b1, 1'b0, 1'b0, "data_at_expiry");
    send(8'h35, 2, 1'b0, 1'b1, 1'b0, "csum_after_expiry");
    send(8'hA5, 2, 1'b0, 1'b0, 1'b0, "sync");
    m_cmd = 8'h03;
    send(8'h03, 2, 1'b0, 1'b0, 1'b0, "cmd");
    m_len = 8'h02;
    send(8'h02, 2, 1'b0, 1'b0, 1'b0, "len");
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    {m_cmd, m_len, m_db, m_di, m_ec} = '0;
    chk_out("mid_reset", 1'b0, 1'b0, 1'b0);
    repeat (TC + 2) begin
      @(posedge i_clk);
      #1;
      chk_out("post_reset_quiet", 1'b0, 1'b0, 1'b0);
    end
    frame(8'h42, 8'h03, '{8'h01, 8'h02, 8'h03}, 1'b0, 0);
    for (int it = 0; it < 60; it++) begin
      kind = int'($urandom_range(0, 9));
      c = 8'($urandom);
      q = {};
      if (kind == 5) begin
        l = 8'($urandom_range(0, MAXLEN));
        repeat (int'(l)) q.push_back(8'($urandom));
        frame(c, l, q, 1'b1, 0);
      end else if (kind == 6) begin
        frame(c, 8'($urandom_range(MAXLEN + 1, 255)), none, 1'b0, 0);
      end else if (kind == 7) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        send(b, g(0), 1'b0, 1'b0, 1'b0, "junk");
      end else if (kind == 8 && ntmo < 6) begin
        ntmo++;
        n = int'($urandom_range(1, 3));
        send(8'hA5, n == 1 ? 1 : 2, 1'b0, 1'b0, 1'b0, "sync");
        if (n > 1) begin
          m_cmd = c;
          send(c, n == 2 ? 1 : 2, 1'b0, 1'b0, 1'b0, "cmd");
        end
        if (n > 2) begin
          m_len = 8'($urandom_range(1, MAXLEN));
          send(m_len, 1, 1'b0, 1'b0, 1'b0, "len");
        end
        expect_timeout("timeout_rand");
      end else begin
        l = 8'($urandom_range(0, MAXLEN));
        repeat (int'(l)) q.push_back(8'($urandom));
        frame(c, l, q, 1'b0, 0);
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
Downstream consumer of uart_rx; takes its one-cycle o_rx_valid/o_rx_byte strobes and assembles command frames. Frame format: SYNC, CMD, LEN, LEN payload bytes, CSUM.
Streams payload bytes to the command layer with an index, then flags the frame as good or bad.
Detects checksum, length and inter-byte timeout errors, and resynchronises on the next SYNC byte.

Parameters:
SyncByte, 8'hA5, frame start marker
MaxLen, 16, maximum legal payload length in bytes (1..255)
TimeoutClks, 3472, max i_clk cycles between bytes inside a frame (about 4 byte times at 10 MHz / 115200 baud)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  synchronous active-low reset
i_rx_valid  in  1  one-cycle strobe: i_rx_byte is valid (from uart_rx o_rx_valid)
i_rx_byte  in  8  received byte (from uart_rx o_rx_byte)
o_cmd  out  8  command byte of current/last frame
o_len  out  8  length byte of current/last frame
o_data_valid  out  1  one-cycle strobe per payload byte
o_data_byte  out  8  payload byte, valid with o_data_valid
o_data_idx  out  8  payload byte index, 0-based
o_frame_valid  out  1  one-cycle pulse: frame accepted, checksum good
o_frame_err  out  1  one-cycle pulse: frame aborted
o_err_code  out  2  0 none, 1 checksum, 2 length, 3 timeout; valid with o_frame_err, held until next error

Behaviour:
- Reset (i_rst_n low at posedge): state IDLE; all outputs 0; checksum, index and timeout counter cleared. Reset mid-frame discards the frame silently, with no o_frame_err.
- Clock and reset: single clock; synchronous active-low reset (i_rst_n).
- States: IDLE, CMD, LEN, PAYLOAD, CSUM. Transitions occur only on i_rx_valid, except timeout.
- IDLE: a byte equal to SyncByte moves to CMD; any other byte is ignored.
- CMD: latch o_cmd; checksum = byte; move to LEN.
- LEN: latch o_len.
  - LEN > MaxLen: pulse o_frame_err with code 2, go to IDLE.
  - LEN == 0: go to CSUM.
  - Otherwise: go to PAYLOAD with index = 0.
  - Checksum += byte in all cases.
- PAYLOAD: each byte is registered to o_data_byte/o_data_idx with o_data_valid high one cycle after i_rx_valid (latency 1). Checksum += byte; index++. After byte LEN-1, go to CSUM.
- CSUM: byte == checksum[7:0] pulses o_frame_valid; otherwise pulse o_frame_err with code 1. Either way, go to IDLE. Pulses are asserted one cycle after the CSUM byte strobe.
- Checksum arithmetic: 8-bit sum of CMD, LEN and payload, modulo 256. Carries are discarded.
- SYNC value inside a frame is treated as data; there is no resync mid-frame.
- Timeout counter:
  - Cleared on every i_rx_valid and in IDLE.
  - Increments each cycle in states other than IDLE.
  - On reaching TimeoutClks-1 without a byte: pulse o_frame_err with code 3, go to IDLE.
- Simultaneous events: if i_rx_valid coincides with timeout expiry, the byte wins and the counter clears.
- o_frame_valid, o_frame_err and o_data_valid are mutually exclusive in any cycle.
- o_cmd/o_len hold their value until the next frame's CMD/LEN byte.
- A back-to-back SYNC on the cycle after CSUM (next strobe) is accepted normally.
- i_rx_valid is assumed never asserted on consecutive cycles (uart_rx guarantee). The design must still process one byte per cycle correctly.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, CMD, LEN, PAYLOAD, CSUM)
  - error code constants (ERR_NONE, ERR_CSUM, ERR_LEN, ERR_TIMEOUT)
  - default sync byte
- One sub-module, uart_timeout_cnt: clear/enable inputs, terminal-count pulse output, parameter TimeoutClks, width $clog2(TimeoutClks+1).

Test Plan:
- Good frame: bytes A5 01 02 10 20 33 -> o_data_valid twice (10 at idx 0, 20 at idx 1), then one o_frame_valid pulse; o_cmd=01, o_len=02, o_frame_err never asserted.
- Checksum wrap: A5 FF 01 02 02 -> o_frame_valid (sum 0x102 mod 256 = 0x02). Then A5 FF 01 02 03 -> o_frame_err with o_err_code=1.
- Length error: A5 07 11 with MaxLen=16 -> o_frame_err and o_err_code=2 one cycle after the LEN strobe; no o_data_valid; next A5 05 00 05 -> o_frame_valid.
- Zero length and junk: 00 FF A5 A5 00 A5 -> leading junk ignored; frame CMD=A5 LEN=00 CSUM=A5 gives o_frame_valid and no data strobes.
- Timeout: A5 03 02 10 then silence -> o_frame_err with o_err_code=3 exactly TimeoutClks-1 cycles after the last strobe. A byte arriving exactly at expiry instead keeps the frame alive.
- Reset mid-frame: i_rst_n low for 1 cycle after A5 03 02 -> all outputs 0, no error pulse; following complete frame parses correctly. Run end to end through uart_rx at 115200 baud.
